// File: rtl/angstrom_pkg.sv
// Shared ALU width, opcode encodings and arbiter FSM states.
// Pure declarations: no latency, no backpressure.
package angstrom_pkg;

    localparam int WIDTH = 8;

    localparam logic [2:0] FUNC_ADI = 3'd0;
    localparam logic [2:0] FUNC_ADD = 3'd1;
    localparam logic [2:0] FUNC_SUB = 3'd2;
    localparam logic [2:0] FUNC_AND = 3'd3;
    localparam logic [2:0] FUNC_ORR = 3'd4;
    localparam logic [2:0] FUNC_XOR = 3'd5;
    localparam logic [2:0] FUNC_LSL = 3'd6;
    localparam logic [2:0] FUNC_LSR = 3'd7;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-port request/response bundle between requesters and the shared ALU arbiter.
// Valid/ready on both channels; the response payload is shared and qualified per port.
interface alu_arbiter_if #(parameter int WIDTH = angstrom_pkg::WIDTH);

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [2:0]       req_func0;
    logic [2:0]       req_func1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             rsp_owner;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_func0, req_func1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_owner
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_func0, req_func1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_owner
    );

endinterface

// File: rtl/alu.sv
// Combinational 8-opcode ALU with zero and carry/borrow flags.
// Zero latency, no handshake.
module alu #(
    parameter int WIDTH = angstrom_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       func,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);
    import angstrom_pkg::*;

    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (func)
            FUNC_ADI, FUNC_ADD: begin
                result = sum_ext[WIDTH-1:0];
                carry  = sum_ext[WIDTH];
            end
            FUNC_SUB: begin
                result = diff_ext[WIDTH-1:0];
                carry  = diff_ext[WIDTH];
            end
            FUNC_AND: result = a & b;
            FUNC_ORR: result = a | b;
            FUNC_XOR: result = a ^ b;
            FUNC_LSL: result = {a[WIDTH-2:0], 1'b0};
            default:  result = {1'b0, a[WIDTH-1:1]};
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the port not granted last wins a tie.
// Combinational; en=0 suppresses every grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready ports; result registered, response one cycle after accept.
// Accepts only when idle or when the held response drains in the same cycle.
module alu_arbiter #(
    parameter int WIDTH = angstrom_pkg::WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    import angstrom_pkg::*;

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic             consume;
    logic             can_accept;
    logic [1:0]       gnt;
    logic             accept;
    logic             sel;
    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [2:0]       alu_func;
    logic             alu_zero, alu_carry;

    assign consume    = (state_q == ARB_RESP) && bus.rsp_ready[owner_q];
    // rst_n gating keeps req_ready low while reset is held, not only after it.
    assign can_accept = rst_n && ((state_q == ARB_IDLE) || consume);

    rr_arb2 u_arb (
        .req  (bus.req_valid),
        .last (last_q),
        .en   (can_accept),
        .gnt  (gnt)
    );

    assign accept = |gnt;
    assign sel    = gnt[1];

    assign alu_a    = sel ? bus.req_a1    : bus.req_a0;
    assign alu_b    = sel ? bus.req_b1    : bus.req_b0;
    assign alu_func = sel ? bus.req_func1 : bus.req_func0;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .func   (alu_func),
        .result (alu_res),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        if (accept) begin
            state_d  = ARB_RESP;
            last_d   = sel;
            owner_d  = sel;
            result_d = alu_res;
            zero_d   = alu_zero;
            carry_d  = alu_carry;
        end else if (consume) begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.rsp_valid  = (state_q == ARB_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_owner  = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reset values, opcode table, directed multi-cycle corners, random vs. model.
module tb_alu_arbiter;
    import angstrom_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(8)) bus();
    alu_arbiter #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       port;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] func;
        logic [7:0] res;
        logic       z;
        logic       c;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op(input logic p, input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        if (p) begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_func1 = f;
        end else begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_func0 = f;
        end
    endtask

    task automatic drain();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        step();
        step();
    endtask

    task automatic chk_rsp(input string name, input logic [1:0] v, input logic [7:0] r,
                           input logic z, input logic c, input logic o);
        chk({name, "_valid"},  bus.rsp_valid, v);
        chk({name, "_result"}, bus.rsp_result, r);
        chk({name, "_zero"},   bus.rsp_zero, z);
        chk({name, "_carry"},  bus.rsp_carry, c);
        chk({name, "_owner"},  bus.rsp_owner, o);
    endtask

    // Reference arithmetic straight from the opcode definitions.
    function automatic logic [9:0] ref_alu(input int a, input int b, input int f);
        int r;
        int c;
        c = 0;
        case (f)
            0, 1: begin r = a + b; c = (r > 255) ? 1 : 0; r = r % 256; end
            2:    begin c = (a < b) ? 1 : 0; r = (a - b + 256) % 256; end
            3:    r = a & b;
            4:    r = a | b;
            5:    r = a ^ b;
            6:    r = (a * 2) % 256;
            default: r = a / 2;
        endcase
        return {r[7:0], (r == 0), c[0]};
    endfunction

    logic [7:0] lsl_in[3];
    logic [7:0] lsl_exp[3];

    // Random-phase model state.
    logic       m_pend, m_owner, m_last, m_z, m_c, m_w;
    logic [7:0] m_res;
    logic [1:0] m_ready;
    logic [9:0] m_out;

    initial begin
        vt[0] = '{1'b0, 8'hFF, 8'h01, FUNC_ADD, 8'h00, 1'b1, 1'b1};
        vt[1] = '{1'b0, 8'h05, 8'h07, FUNC_SUB, 8'hFE, 1'b0, 1'b1};
        vt[2] = '{1'b1, 8'hF0, 8'h0F, FUNC_XOR, 8'hFF, 1'b0, 1'b0};
        vt[3] = '{1'b1, 8'h10, 8'h20, FUNC_ADI, 8'h30, 1'b0, 1'b0};
        vt[4] = '{1'b0, 8'hF0, 8'h0F, FUNC_AND, 8'h00, 1'b1, 1'b0};
        vt[5] = '{1'b1, 8'hA0, 8'h05, FUNC_ORR, 8'hA5, 1'b0, 1'b0};
        vt[6] = '{1'b0, 8'h81, 8'h00, FUNC_LSL, 8'h02, 1'b0, 1'b0};
        vt[7] = '{1'b1, 8'h81, 8'h00, FUNC_LSR, 8'h40, 1'b0, 1'b0};
        vt[8] = '{1'b0, 8'h07, 8'h07, FUNC_SUB, 8'h00, 1'b1, 1'b0};
        vt[9] = '{1'b1, 8'h80, 8'h80, FUNC_ADD, 8'h00, 1'b1, 1'b1};
        lsl_in[0] = 8'h81; lsl_in[1] = 8'h40; lsl_in[2] = 8'h01;
        lsl_exp[0] = 8'h02; lsl_exp[1] = 8'h80; lsl_exp[2] = 8'h02;

        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        set_op(1'b0, 8'h00, 8'h00, FUNC_ADD);
        set_op(1'b1, 8'h00, 8'h00, FUNC_ADD);

        // Reset values, with requests already pending.
        #3;
        bus.req_valid = 2'b11;
        settle();
        chk("reset_req_ready", bus.req_ready, 2'b00);
        chk_rsp("reset", 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);

        // First cycle after reset: both valid, port 0 first, then alternation.
        set_op(1'b0, 8'h05, 8'h07, FUNC_SUB);
        set_op(1'b1, 8'hF0, 8'h0F, FUNC_XOR);
        bus.rsp_ready = 2'b11;
        step();
        step();
        rst_n = 1'b1;
        settle();
        chk("first_req_ready", bus.req_ready, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0) begin
                chk_rsp("alt_p0", 2'b01, 8'hFE, 1'b0, 1'b1, 1'b0);
                chk("alt_req_ready", bus.req_ready, 2'b10);
            end else begin
                chk_rsp("alt_p1", 2'b10, 8'hFF, 1'b0, 1'b0, 1'b1);
                chk("alt_req_ready", bus.req_ready, 2'b01);
            end
        end
        drain();
        chk("drained_idle", bus.rsp_valid, 2'b00);

        // Opcode table, one port at a time from idle.
        for (int i = 0; i < 10; i++) begin
            set_op(vt[i].port, vt[i].a, vt[i].b, vt[i].func);
            bus.req_valid = vt[i].port ? 2'b10 : 2'b01;
            bus.rsp_ready = 2'b11;
            settle();
            chk("tbl_req_ready", bus.req_ready, vt[i].port ? 2'b10 : 2'b01);
            step();
            bus.req_valid = 2'b00;
            settle();
            chk_rsp("tbl", vt[i].port ? 2'b10 : 2'b01, vt[i].res, vt[i].z, vt[i].c, vt[i].port);
            step();
        end
        drain();

        // Backpressure on port 0's response while port 1 waits.
        bus.rsp_ready = 2'b10;
        set_op(1'b0, 8'h01, 8'h02, FUNC_ADD);
        bus.req_valid = 2'b01;
        settle();
        chk("bp_req_ready0", bus.req_ready, 2'b01);
        step();
        set_op(1'b1, 8'h0C, 8'h30, FUNC_ORR);
        bus.req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_req_ready_hold", bus.req_ready, 2'b00);
            chk_rsp("bp_hold", 2'b01, 8'h03, 1'b0, 1'b0, 1'b0);
            step();
        end
        bus.rsp_ready = 2'b11;
        settle();
        chk("bp_req_ready_release", bus.req_ready, 2'b10);
        step();
        bus.req_valid = 2'b00;
        settle();
        chk_rsp("bp_p1", 2'b10, 8'h3C, 1'b0, 1'b0, 1'b1);
        drain();

        // Back-to-back LSL stream on port 0.
        bus.req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            set_op(1'b0, lsl_in[i], 8'h00, FUNC_LSL);
            settle();
            chk("lsl_req_ready", bus.req_ready, 2'b01);
            step();
            if (i == 2) bus.req_valid = 2'b00;
            settle();
            chk_rsp("lsl", 2'b01, lsl_exp[i], 1'b0, 1'b0, 1'b0);
        end
        drain();

        // Reset pulse while a port-0 response is held.
        bus.rsp_ready = 2'b00;
        set_op(1'b0, 8'h11, 8'h22, FUNC_ADD);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        settle();
        chk_rsp("pre_rst", 2'b01, 8'h33, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_rsp_valid", bus.rsp_valid, 2'b00);
        bus.req_valid = 2'b11;
        settle();
        chk("rst_req_ready", bus.req_ready, 2'b00);
        step();
        rst_n = 1'b1;
        bus.rsp_ready = 2'b11;
        settle();
        chk("post_rst_grant", bus.req_ready, 2'b01);
        drain();

        // Withdrawn port-1 request while port 0 wins.
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = 2'b00;
        step();
        set_op(1'b0, 8'h02, 8'h03, FUNC_ADD);
        bus.req_valid = 2'b11;
        settle();
        chk("wd_grant", bus.req_ready, 2'b01);
        step();
        bus.req_valid = 2'b00;
        settle();
        chk_rsp("wd_p0", 2'b01, 8'h05, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wd_no_p1_rsp", bus.rsp_valid, 2'b00);
        end
        bus.req_valid = 2'b11;
        settle();
        chk("wd_last_is_p0", bus.req_ready, 2'b10);
        bus.req_valid = 2'b00;
        drain();

        // Random traffic against the reference model.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_pend = 1'b0; m_owner = 1'b0; m_last = 1'b1;
        m_res = 8'h00; m_z = 1'b0; m_c = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            bus.req_valid    = 2'($urandom_range(0, 3));
            bus.rsp_ready[0] = ($urandom_range(0, 3) != 0);
            bus.rsp_ready[1] = ($urandom_range(0, 3) != 0);
            set_op(1'b0, 8'($urandom), 8'($urandom), 3'($urandom));
            set_op(1'b1, 8'($urandom), 8'($urandom), 3'($urandom));
            settle();
            m_w = (bus.req_valid == 2'b11) ? ~m_last : bus.req_valid[1];
            m_ready = ((!m_pend || bus.rsp_ready[m_owner]) && (bus.req_valid != 2'b00))
                      ? (m_w ? 2'b10 : 2'b01) : 2'b00;
            chk("rnd_req_ready", bus.req_ready, m_ready);
            chk("rnd_rsp_valid", bus.rsp_valid, m_pend ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
            if (m_pend) begin
                chk("rnd_result", bus.rsp_result, m_res);
                chk("rnd_flags", {bus.rsp_zero, bus.rsp_carry}, {m_z, m_c});
                chk("rnd_owner", bus.rsp_owner, m_owner);
            end
            if (m_ready != 2'b00) begin
                if (m_w) m_out = ref_alu(bus.req_a1, bus.req_b1, bus.req_func1);
                else     m_out = ref_alu(bus.req_a0, bus.req_b0, bus.req_func0);
                m_pend  = 1'b1;
                m_owner = m_w;
                m_last  = m_w;
                m_res   = m_out[9:2];
                m_z     = m_out[1];
                m_c     = m_out[0];
            end else if (m_pend && bus.rsp_ready[m_owner]) begin
                m_pend = 1'b0;
            end
        end
        bus.req_valid = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
